systolic_mac_pe: RTL and testbench

//   Parametrised signed multiply-accumulate element for the output-stationary systolic array.

---
 rtl/systolic_mac_pe.sv | 200 ++++++++++++++++++++
 tb/tb_systolic_mac_pe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mac_pe.sv
// -----------------------------------------------------------------------------
// systolic_mac_pe
//   Signed multiply-accumulate processing element for an output-stationary
//   systolic array. Activations enter from the west and leave east one cycle
//   later. Each accepted beat is multiplied by the locally held active weight
//   in a registered stage. The product then feeds a bias-seeded accumulator
//   that can optionally saturate. A small flush FSM closes a tile and emits a
//   one-cycle result strobe.
//
//   Handshake: a_valid_in qualifies a_in for one cycle. There is no
//   back-pressure, so every valid beat presented while the FSM is in IDLE or
//   RUN is consumed. acc_valid is a single-cycle strobe that marks acc_out as
//   the final tile result.
//
// Ports
//   clk, rst_n                clock (rising edge), async active-low reset
//   a_in, a_valid_in          activation beat from west neighbour
//   a_out, a_valid_out        registered pass-through to east neighbour
//   w_in, w_load_en           write shadow weight
//   w_swap                    copy shadow weight into active weight
//   bias_in, bias_en          seed accumulator with sign-extended bias
//   clear                     synchronous clear of acc/pipeline/flags/FSM
//   flush                     close tile: drain pipeline, strobe result
//   acc_out                   accumulator value (every cycle)
//   acc_valid                 one-cycle final-result strobe
//   busy                      FSM not in IDLE
//   ovf                       sticky overflow flag
// -----------------------------------------------------------------------------
module systolic_mac_pe #(
   parameter int DATA_W   = 8,
   parameter int ACC_W    = 16,
   parameter bit SATURATE = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] a_in,
   input  logic              a_valid_in,
   output logic [DATA_W-1:0] a_out,
   output logic              a_valid_out,
   input  logic [DATA_W-1:0] w_in,
   input  logic              w_load_en,
   input  logic              w_swap,
   input  logic [DATA_W-1:0] bias_in,
   input  logic              bias_en,
   input  logic              clear,
   input  logic              flush,
   output logic [ACC_W-1:0]  acc_out,
   output logic              acc_valid,
   output logic              busy,
   output logic              ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Exposed by name so assertions and checkers can bind to the FSM.
   state_t state;
   state_t state_next;

   logic                       accept;
   logic [DATA_W-1:0]          w_shadow;
   logic [DATA_W-1:0]          w_active;
   logic signed [2*DATA_W-1:0] prod;
   logic                       p_valid;
   logic [ACC_W-1:0]           acc;

   logic signed [2*DATA_W-1:0] a_ext;
   logic signed [2*DATA_W-1:0] w_ext;
   logic [ACC_W-1:0]           base;
   logic [ACC_W-1:0]           addend;
   logic [ACC_W:0]             sum_ext;
   logic                       add_ovf;
   logic [ACC_W-1:0]           sum;

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else if (clear) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (flush) begin
               state_next = FLUSH;
            end else if (a_valid_in || bias_en) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (flush) begin
               state_next = FLUSH;
            end
         end
         // One cycle in FLUSH lets the last accepted product land.
         FLUSH:   state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      acc_valid = (state == DONE);
      accept    = (state == IDLE) || (state == RUN);
   end

   // ---------------------------------------------------- pass-through path
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_out       <= '0;
         a_valid_out <= 1'b0;
      end else begin
         a_out       <= a_in;
         a_valid_out <= a_valid_in;
      end
   end

   // ------------------------------------------- double-buffered weight
   // Swap reads the shadow before this cycle's load, so a simultaneous
   // load+swap moves the old shadow into active.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_shadow <= '0;
         w_active <= '0;
      end else begin
         if (w_load_en) begin
            w_shadow <= w_in;
         end
         if (w_swap) begin
            w_active <= w_shadow;
         end
      end
   end

   // ---------------------------------------------------- stage 1: multiply
   // Operands are widened first so the product is computed at full width.
   always_comb begin
      a_ext = (2*DATA_W)'($signed(a_in));
      w_ext = (2*DATA_W)'($signed(w_active));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod    <= '0;
         p_valid <= 1'b0;
      end else if (clear) begin
         prod    <= '0;
         p_valid <= 1'b0;
      end else begin
         prod    <= a_ext * w_ext;
         p_valid <= a_valid_in && accept;
      end
   end

   // ------------------------------------------------- stage 2: accumulate
   // Bias replaces the running sum but a landing product is still added.
   always_comb begin
      base    = bias_en ? ACC_W'($signed(bias_in)) : acc;
      addend  = p_valid ? ACC_W'(prod) : '0;
      sum_ext = {base[ACC_W-1], base} + {addend[ACC_W-1], addend};
      // Guard bit and result sign disagree only on signed overflow.
      add_ovf = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
      if (add_ovf && SATURATE) begin
         sum = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
      end else begin
         sum = sum_ext[ACC_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         ovf <= 1'b0;
      end else if (clear) begin
         acc <= '0;
         ovf <= 1'b0;
      end else begin
         acc <= sum;
         // A new tile starts with a clean flag unless its own seed add overflows.
         ovf <= bias_en ? add_ovf : (ovf | add_ovf);
      end
   end

   assign acc_out = acc;

endmodule

// File: tb/tb_systolic_mac_pe.sv
module tb_systolic_mac_pe;
   localparam int DW = 8;
   localparam int AW = 16;

   // ---------------------------------------------------- clock / reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [DW-1:0] a_in, w_in, bias_in;
   logic          a_valid_in, w_load_en, w_swap, bias_en, clear, flush;

   // Saturating instance (s) and wrapping instance (w) share all inputs.
   logic [DW-1:0] a_out_s, a_out_w;
   logic          a_valid_out_s, a_valid_out_w;
   logic [AW-1:0] acc_s, acc_w;
   logic          valid_s, valid_w, busy_s, busy_w, ovf_s, ovf_w;

   systolic_mac_pe #(.DATA_W(DW), .ACC_W(AW), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .rst_n(rst_n),
      .a_in(a_in), .a_valid_in(a_valid_in),
      .a_out(a_out_s), .a_valid_out(a_valid_out_s),
      .w_in(w_in), .w_load_en(w_load_en), .w_swap(w_swap),
      .bias_in(bias_in), .bias_en(bias_en),
      .clear(clear), .flush(flush),
      .acc_out(acc_s), .acc_valid(valid_s), .busy(busy_s), .ovf(ovf_s)
   );

   systolic_mac_pe #(.DATA_W(DW), .ACC_W(AW), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .rst_n(rst_n),
      .a_in(a_in), .a_valid_in(a_valid_in),
      .a_out(a_out_w), .a_valid_out(a_valid_out_w),
      .w_in(w_in), .w_load_en(w_load_en), .w_swap(w_swap),
      .bias_in(bias_in), .bias_en(bias_en),
      .clear(clear), .flush(flush),
      .acc_out(acc_w), .acc_valid(valid_w), .busy(busy_w), .ovf(ovf_w)
   );

   // ---------------------------------------------------- scoreboard
   int checks = 0;
   int errors = 0;
   logic [AW:0] exp_s_q[$];   // {ovf, acc}
   logic [AW:0] exp_w_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
      end
   endtask

   task automatic check_acc(input string name, input logic signed [AW-1:0] req);
      check({name, "_sat"},  {16'b0, acc_s}, {16'b0, req});
      check({name, "_wrap"}, {16'b0, acc_w}, {16'b0, req});
   endtask

   task automatic expect_result(input logic os, input logic signed [AW-1:0] as,
                                input logic ow, input logic signed [AW-1:0] aw);
      exp_s_q.push_back({os, as});
      exp_w_q.push_back({ow, aw});
   endtask

   // Monitor: every result strobe pops one expected {ovf, acc}.
   always @(negedge clk) begin
      if (valid_s) begin
         checks++;
         if (exp_s_q.size() == 0) begin
            errors++;
            $display("FAIL result_sat: unexpected strobe acc=%0d at %0t", $signed(acc_s), $time);
         end else begin
            logic [AW:0] e;
            e = exp_s_q.pop_front();
            if ({ovf_s, acc_s} !== e) begin
               errors++;
               $display("FAIL result_sat: got ovf=%0b acc=%0d expected ovf=%0b acc=%0d at %0t",
                        ovf_s, $signed(acc_s), e[AW], $signed(e[AW-1:0]), $time);
            end
         end
      end
      if (valid_w) begin
         checks++;
         if (exp_w_q.size() == 0) begin
            errors++;
            $display("FAIL result_wrap: unexpected strobe acc=%0d at %0t", $signed(acc_w), $time);
         end else begin
            logic [AW:0] e;
            e = exp_w_q.pop_front();
            if ({ovf_w, acc_w} !== e) begin
               errors++;
               $display("FAIL result_wrap: got ovf=%0b acc=%0d expected ovf=%0b acc=%0d at %0t",
                        ovf_w, $signed(acc_w), e[AW], $signed(e[AW-1:0]), $time);
            end
         end
      end
   end

   // ---------------------------------------------------- driver tasks
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      a_in = '0; a_valid_in = 1'b0; w_in = '0; w_load_en = 1'b0; w_swap = 1'b0;
      bias_in = '0; bias_en = 1'b0; clear = 1'b0; flush = 1'b0;
   endtask

   task automatic load_weight(input logic signed [DW-1:0] w);
      idle(); w_in = w; w_load_en = 1'b1; tick();
      idle(); w_swap = 1'b1; tick();
      idle();
   endtask

   task automatic beat(input logic signed [DW-1:0] a, input logic fl);
      a_in = a; a_valid_in = 1'b1; flush = fl;
   endtask

   task automatic seed(input logic signed [DW-1:0] b);
      bias_in = b; bias_en = 1'b1;
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_acc"},   {16'b0, acc_s, acc_w} == 0 ? 32'd0 : 32'd1, 32'd0);
      check({name, "_flags"}, {26'b0, valid_s, valid_w, busy_s, busy_w, ovf_s, ovf_w}, 32'd0);
      check({name, "_aout"},  {14'b0, a_out_s, a_out_w, a_valid_out_s, a_valid_out_w}, 32'd0);
   endtask

   // ---------------------------------------------------- stimulus
   initial begin
      idle();
      rst_n = 1'b0;

      // 1: reset held while inputs toggle
      for (int i = 0; i < 4; i++) begin
         a_in = 8'($urandom_range(0, 255)); a_valid_in = 1'($urandom_range(0, 1));
         w_in = 8'($urandom_range(0, 255)); w_load_en = 1'b1; w_swap = 1'b1;
         bias_in = 8'($urandom_range(0, 255)); bias_en = 1'($urandom_range(0, 1));
         flush = 1'($urandom_range(0, 1));
         tick();
         check_all_zero("reset_hold");
      end
      idle();
      #2 rst_n = 1'b1;
      tick(); tick();
      check_all_zero("reset_release");

      // 2: dot product 5 + 3*(2 - 4 + 7) = 20, strobe timing
      load_weight(8'sd3);
      seed(8'sd5); beat(8'sd2, 1'b0); tick();
      idle(); beat(-8'sd4, 1'b0); tick();
      idle(); beat(8'sd7, 1'b1);
      expect_result(1'b0, 16'sd20, 1'b0, 16'sd20);
      tick(); idle();
      check("dot_strobe_t1", {31'b0, valid_s}, 32'd0);
      check("dot_busy_t1", {31'b0, busy_s}, 32'd1);
      tick();
      check("dot_strobe_t2", {31'b0, valid_s}, 32'd1);
      tick();
      check("dot_busy_t3", {30'b0, busy_s, valid_s}, 32'd0);

      // 3: double buffer, beat in swap cycle uses old weight: 1 + 20 - 10
      load_weight(8'sd2);
      seed(8'sd1); w_in = -8'sd1; w_load_en = 1'b1; tick();
      idle(); w_swap = 1'b1; beat(8'sd10, 1'b0); tick();
      idle(); beat(8'sd10, 1'b1);
      expect_result(1'b0, 16'sd11, 1'b0, 16'sd11);
      tick(); idle(); tick(); tick();

      // 4: overflow, 127 + 3*127*127 = 48514
      load_weight(8'sd127);
      seed(8'sd127); beat(8'sd127, 1'b0); tick();
      idle(); beat(8'sd127, 1'b0); tick();
      idle(); beat(8'sd127, 1'b1);
      expect_result(1'b1, 16'sd32767, 1'b1, -16'sd17022);
      tick(); idle(); tick(); tick();
      check("ovf_sticky", {30'b0, ovf_s, ovf_w}, 32'd3);
      seed(8'sd0); tick(); idle();
      check("ovf_cleared_by_bias", {30'b0, ovf_s, ovf_w}, 32'd0);
      check_acc("bias_zero_seed", 16'sd0);
      flush = 1'b1;
      expect_result(1'b0, 16'sd0, 1'b0, 16'sd0);
      tick(); idle(); tick(); tick();

      // 5a: bias 9 in the cycle product 6 lands -> 15
      load_weight(8'sd3);
      beat(8'sd2, 1'b0); tick();
      idle(); seed(8'sd9); tick();
      idle(); flush = 1'b1;
      expect_result(1'b0, 16'sd15, 1'b0, 16'sd15);
      tick(); idle(); tick(); tick();

      // 5b: load+swap together -> active takes old shadow (5), shadow becomes -2
      w_in = 8'sd5; w_load_en = 1'b1; tick();
      idle(); w_in = -8'sd2; w_load_en = 1'b1; w_swap = 1'b1; tick();
      idle(); seed(8'sd0); beat(8'sd1, 1'b1);
      expect_result(1'b0, 16'sd5, 1'b0, 16'sd5);
      tick(); idle(); tick(); tick();
      w_swap = 1'b1; tick();
      idle(); seed(8'sd0); beat(8'sd3, 1'b1);
      expect_result(1'b0, -16'sd6, 1'b0, -16'sd6);
      tick(); idle(); tick(); tick();

      // 5c: clear beats bias_en and kills in-flight product; pass-through unaffected
      seed(8'sd1); beat(8'sd4, 1'b0); tick();
      idle(); beat(8'sd4, 1'b0); tick();
      idle(); clear = 1'b1; seed(8'sd9); beat(8'sd4, 1'b0); tick();
      idle();
      check_acc("clear_bias", 16'sd0);
      check("clear_busy", {30'b0, busy_s, ovf_s}, 32'd0);
      check("clear_passthru", {24'b0, a_out_s}, 32'd4);
      tick();
      check_acc("clear_pipeline", 16'sd0);

      // 6: beats in FLUSH/DONE are ignored but still pass east
      seed(8'sd0); beat(8'sd1, 1'b1);   // active weight is -2
      expect_result(1'b0, -16'sd2, 1'b0, -16'sd2);
      tick(); idle(); beat(8'sd50, 1'b0); tick();
      check("gate_passthru_flush", {23'b0, a_valid_out_s, a_out_s}, {23'b0, 1'b1, 8'd50});
      idle(); beat(8'sd60, 1'b0); tick();
      idle();
      check("gate_passthru_done", {23'b0, a_valid_out_w, a_out_w}, {23'b0, 1'b1, 8'd60});
      tick();
      check_acc("gate_acc_hold", -16'sd2);

      // 6: asynchronous reset while in FLUSH suppresses the strobe
      seed(8'sd0); beat(8'sd3, 1'b1); tick();
      idle();
      check("rst_in_flush_busy", {31'b0, busy_s}, 32'd1);
      #1 rst_n = 1'b0;
      #1 check_all_zero("rst_in_flush");
      tick(); tick();
      #2 rst_n = 1'b1;
      tick(); tick(); tick();
      check_all_zero("rst_after");

      // Every issued result must have been strobed.
      tick(); tick();
      check("queue_drain", exp_s_q.size() + exp_w_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
